// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline stall/flush/PC-control sequencer for call, return, halt and illegal-opcode hazards
module hazard_unit #(
  parameter int CALL_STALL_CYCLES = 2,
  parameter int RET_DRAIN_CYCLES  = 3,
  parameter int CNT_W             = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic id_valid,
  input  logic stall_fetch,
  input  logic return_in_pipeline,
  input  logic halt,
  input  logic illegal_opcode_exception,
  input  logic mem_busy,
  input  logic wake,
  output logic pc_stall,
  output logic if_id_stall,
  output logic if_id_flush,
  output logic id_ex_stall,
  output logic id_ex_flush,
  output logic ret_pc_load,
  output logic halted
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CALL_STALL = 2'd1,
    RET_DRAIN  = 2'd2,
    HALTED     = 2'd3
  } state_t;

  // The decode cycle is the first frozen cycle, so the counter is loaded
  // with (total - 2) and the sequence ends in the cycle it reads zero.
  localparam logic [CNT_W-1:0] CALL_LOAD = CNT_W'(CALL_STALL_CYCLES - 2);
  localparam logic [CNT_W-1:0] RET_LOAD  = CNT_W'(RET_DRAIN_CYCLES - 2);

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;

  // Decode hazards only count when a real instruction sits in ID.
  logic take_ill, take_halt, take_ret, take_call;
  assign take_ill  = id_valid && illegal_opcode_exception;
  assign take_halt = id_valid && halt;
  assign take_ret  = id_valid && return_in_pipeline;
  assign take_call = id_valid && stall_fetch;

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Next-state logic: wake out of HALTED beats a memory freeze; otherwise a
  // freeze holds everything in place.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    if (state == HALTED) begin
      if (wake) next_state = IDLE;
    end else if (!mem_busy) begin
      case (state)
        IDLE: begin
          if (take_ill) begin
            next_state = IDLE;
          end else if (take_halt) begin
            next_state = HALTED;
          end else if (take_ret) begin
            if (RET_DRAIN_CYCLES > 1) begin
              next_state = RET_DRAIN;
              next_cnt   = RET_LOAD;
            end
          end else if (take_call) begin
            if (CALL_STALL_CYCLES > 1) begin
              next_state = CALL_STALL;
              next_cnt   = CALL_LOAD;
            end
          end
        end
        CALL_STALL, RET_DRAIN: begin
          if (cnt == '0) next_state = IDLE;
          else           next_cnt   = cnt - 1'b1;
        end
        default: next_state = state;
      endcase
    end
  end

  // Output decode from state, counter and current inputs.
  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_stall = 1'b0;
    id_ex_flush = 1'b0;
    ret_pc_load = 1'b0;
    halted      = 1'b0;
    if (rst) begin
      pc_stall = 1'b0;
    end else if (state == HALTED) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      halted      = 1'b1;
      id_ex_stall = mem_busy && !wake;
    end else if (mem_busy) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_stall = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (take_ill) begin
            id_ex_flush = 1'b1;
          end else if (take_halt) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end else if (take_ret) begin
            pc_stall    = 1'b1;
            if_id_flush = 1'b1;
            ret_pc_load = (RET_DRAIN_CYCLES == 1);
          end else if (take_call) begin
            pc_stall    = 1'b1;
            if_id_flush = 1'b1;
          end
        end
        CALL_STALL: begin
          pc_stall    = 1'b1;
          if_id_flush = 1'b1;
        end
        RET_DRAIN: begin
          pc_stall    = 1'b1;
          if_id_flush = 1'b1;
          ret_pc_load = (cnt == '0);
        end
        default: pc_stall = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed-vector self-checking bench for hazard_unit
module tb_hazard_unit;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, stall_fetch, return_in_pipeline, halt, illegal_opcode_exception, mem_busy, wake;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ret_pc_load, halted;

  int total = 0;
  int bad   = 0;

  // input vector bits: {id_valid, call, ret, halt, illegal, mem_busy, wake}
  localparam logic [6:0] I_V    = 7'b1000000;
  localparam logic [6:0] I_CALL = 7'b0100000;
  localparam logic [6:0] I_RET  = 7'b0010000;
  localparam logic [6:0] I_HALT = 7'b0001000;
  localparam logic [6:0] I_ILL  = 7'b0000100;
  localparam logic [6:0] I_BUSY = 7'b0000010;
  localparam logic [6:0] I_WAKE = 7'b0000001;

  // output vector bits: {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ret_pc_load, halted}
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_PC   = 7'b1000000;
  localparam logic [6:0] O_IFS  = 7'b0100000;
  localparam logic [6:0] O_IFF  = 7'b0010000;
  localparam logic [6:0] O_IDS  = 7'b0001000;
  localparam logic [6:0] O_IDF  = 7'b0000100;
  localparam logic [6:0] O_RPL  = 7'b0000010;
  localparam logic [6:0] O_HLT  = 7'b0000001;

  localparam logic [6:0] O_FRZ  = O_PC | O_IFF;
  localparam logic [6:0] O_BUSY = O_PC | O_IFS | O_IDS;
  localparam logic [6:0] O_HOLD = O_PC | O_IFS | O_HLT;

  hazard_unit #(
    .CALL_STALL_CYCLES(2),
    .RET_DRAIN_CYCLES (3),
    .CNT_W            (4)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .id_valid                (id_valid),
    .stall_fetch             (stall_fetch),
    .return_in_pipeline      (return_in_pipeline),
    .halt                    (halt),
    .illegal_opcode_exception(illegal_opcode_exception),
    .mem_busy                (mem_busy),
    .wake                    (wake),
    .pc_stall                (pc_stall),
    .if_id_stall             (if_id_stall),
    .if_id_flush             (if_id_flush),
    .id_ex_stall             (id_ex_stall),
    .id_ex_flush             (id_ex_flush),
    .ret_pc_load             (ret_pc_load),
    .halted                  (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ret_pc_load, halted};
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [6:0] v);
    {id_valid, stall_fetch, return_in_pipeline, halt, illegal_opcode_exception, mem_busy, wake} = v;
  endtask

  // Drive at the falling edge, check outputs 1 ns later, advance one cycle.
  task automatic cyc(input string tag, input logic [6:0] v, input logic [6:0] exp);
    drive(v);
    #1;
    check(tag, outs(), exp);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive(I_V | I_CALL);
    @(negedge clk);
    #1;
    check("reset_outs_forced_0", outs(), O_NONE);
    @(negedge clk);
    rst = 1'b0;

    cyc("idle_quiet", O_NONE, O_NONE);
    cyc("idle_flags_no_valid", I_CALL | I_RET | I_HALT, O_NONE);

    // call: two frozen cycles
    cyc("call_c1", I_V | I_CALL, O_FRZ);
    cyc("call_c2", O_NONE, O_FRZ);
    cyc("call_done", O_NONE, O_NONE);

    // return: three frozen cycles, load in the last
    cyc("ret_c1", I_V | I_RET, O_FRZ);
    cyc("ret_c2", O_NONE, O_FRZ);
    cyc("ret_c3_load", O_NONE, O_FRZ | O_RPL);
    cyc("ret_done", O_NONE, O_NONE);

    // return interrupted by two busy cycles
    cyc("retb_c1", I_V | I_RET, O_FRZ);
    cyc("retb_busy1", I_BUSY, O_BUSY);
    cyc("retb_busy2", I_BUSY | I_V | I_CALL, O_BUSY);
    cyc("retb_c2", O_NONE, O_FRZ);
    cyc("retb_c3_load", O_NONE, O_FRZ | O_RPL);
    cyc("retb_done", O_NONE, O_NONE);

    // busy in IDLE swallows a decoded call
    cyc("idle_busy_call", I_V | I_CALL | I_BUSY, O_BUSY);
    cyc("idle_busy_after", O_NONE, O_NONE);

    // halt, 10 halted cycles with wake in the 10th
    cyc("halt_entry", I_V | I_HALT, O_PC | O_IFS | O_IDF);
    for (int i = 0; i < 9; i++)
      cyc($sformatf("halted_%0d", i), (i == 3) ? (I_V | I_RET) : O_NONE, O_HOLD);
    cyc("halted_wake", I_WAKE, O_HOLD);
    cyc("after_wake", O_NONE, O_NONE);

    // wake while memory is busy still leaves HALTED
    cyc("halt2_entry", I_V | I_HALT, O_PC | O_IFS | O_IDF);
    cyc("halt2_wake_busy", I_WAKE | I_BUSY, O_HOLD);
    cyc("halt2_after_busy", I_BUSY, O_BUSY);
    cyc("halt2_after", O_NONE, O_NONE);

    // illegal beats halt
    cyc("ill_halt", I_V | I_ILL | I_HALT, O_IDF);
    cyc("ill_after", O_NONE, O_NONE);
    cyc("ill_then_call_c1", I_V | I_CALL, O_FRZ);
    cyc("ill_then_call_c2", O_NONE, O_FRZ);
    cyc("ill_then_call_done", O_NONE, O_NONE);

    // back-to-back: ret presented during call stall is ignored, accepted next cycle
    cyc("b2b_call_c1", I_V | I_CALL, O_FRZ);
    cyc("b2b_call_c2_ign", I_V | I_RET, O_FRZ);
    cyc("b2b_ret_c1", I_V | I_RET, O_FRZ);
    cyc("b2b_ret_c2", O_NONE, O_FRZ);
    cyc("b2b_ret_c3", O_NONE, O_FRZ | O_RPL);
    cyc("b2b_done", O_NONE, O_NONE);

    // reset during RET_DRAIN with cnt=1 aborts without a load
    cyc("rstmid_ret_c1", I_V | I_RET, O_FRZ);
    rst = 1'b1;
    #1;
    check("rstmid_outs_0", outs(), O_NONE);
    @(negedge clk);
    rst = 1'b0;
    cyc("rstmid_after1", O_NONE, O_NONE);
    cyc("rstmid_after2", O_NONE, O_NONE);
    cyc("rstmid_after3", O_NONE, O_NONE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
